avgmax_serializer: RTL and testbench

- Post-processing stage that sits directly downstream of the write-back/SRAM path.
- After the result SRAM has been filled, it reads one row of N_WORDS result words back from the SRAM.
- It computes the row maximum and the row average, then shifts the selected 17-bit result out MSB-first on P_out.
- It drives the SRAM read side (cs_n, we_n, address) while busy; write-back owns the SRAM otherwise.

---
 rtl/avgmax_serializer_pkg.sv | 21 ++
 rtl/avgmax_serializer_if.sv | 15 +
 rtl/avgmax_serializer_acc.sv | 31 +++
 rtl/avgmax_serializer.sv | 119 +++++++++++
 tb/tb_avgmax_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avgmax_serializer_pkg.sv
// Shared constants for the avg/max serializer: FSM encoding, result and SRAM widths.
package avgmax_serializer_pkg;

  localparam int RES_W       = 17;
  localparam int SRAM_DW     = 32;
  localparam int N_WORDS_DEF = 16;
  localparam int LOG2_N_DEF  = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_CALC  = 3'd3;
  localparam logic [2:0] S_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Counter width able to hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/avgmax_serializer_if.sv
// SRAM read-side bus shared between the serializer and the result SRAM.
interface avgmax_serializer_if
  import avgmax_serializer_pkg::*;
#(
  parameter int ADDR_W = 8
);
  logic               ry;
  logic [SRAM_DW-1:0] read_data;
  logic               cs_n;
  logic               we_n;
  logic [ADDR_W-1:0]  address;

  modport master (input ry, read_data, output cs_n, we_n, address);
  modport slave  (output ry, read_data, input cs_n, we_n, address);
endinterface

// File: rtl/avgmax_serializer_acc.sv
// Row accumulators: running sum (wide enough to never overflow) and unsigned running max.
module avgmax_acc
  import avgmax_serializer_pkg::*;
#(
  parameter int DATA_W = RES_W,
  parameter int LOG2_N = LOG2_N_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     acc_en,
  input  logic [DATA_W-1:0]        d,
  output logic [DATA_W+LOG2_N-1:0] sum,
  output logic [DATA_W-1:0]        max
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sum <= '0;
      max <= '0;
    end else if (clear) begin
      sum <= '0;
      max <= '0;
    end else if (acc_en) begin
      sum <= sum + {{LOG2_N{1'b0}}, d};
      // strict compare: a tie keeps the current value
      if (d > max) max <= d;
    end
  end

endmodule

// File: rtl/avgmax_serializer.sv
// Reads one row of result words from SRAM, reduces to max or average and
// shifts the selected value out MSB-first.
module avgmax_serializer
  import avgmax_serializer_pkg::*;
#(
  parameter int N_WORDS = N_WORDS_DEF,
  parameter int LOG2_N  = LOG2_N_DEF,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = RES_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  avgmax_en,
  input  logic                  P_s,
  input  logic [ADDR_W-1:0]     base_addr,
  avgmax_serializer_if.master   sram,
  output logic                  P_out,
  output logic                  p_valid,
  output logic                  busy,
  output logic                  avgmax_done
);

  localparam int BC_W = cnt_w(DATA_W);

  localparam logic [LOG2_N:0] LAST_RD  = (LOG2_N+1)'(N_WORDS - 1);
  localparam logic [LOG2_N:0] RD_ONE   = (LOG2_N+1)'(1);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] BIT_ONE  = BC_W'(1);

  logic [2:0]               state;
  logic                     p_s_q;
  logic [ADDR_W-1:0]        base_q;
  logic [LOG2_N:0]          rd_cnt;
  logic                     rd_vld;
  logic [DATA_W-1:0]        shreg;
  logic [BC_W-1:0]          bit_cnt;
  logic                     issue;
  logic                     acc_clr;
  logic [DATA_W+LOG2_N-1:0] sum;
  logic [DATA_W-1:0]        max_v;
  logic [DATA_W-1:0]        avg;
  logic                     unused_hi;

  // A read goes out in the same cycle ry is seen high, so a stall costs exactly one cycle per ry=0.
  assign issue        = (state == S_READ) && sram.ry;
  assign acc_clr      = (state == S_IDLE) && avgmax_en;
  assign sram.cs_n    = ~issue;
  assign sram.we_n    = 1'b1;
  assign sram.address = (state == S_READ) ? base_q + ADDR_W'(rd_cnt) : '0;
  assign busy         = (state != S_IDLE);
  assign avg          = sum[DATA_W+LOG2_N-1:LOG2_N];
  assign unused_hi    = ^sram.read_data[SRAM_DW-1:DATA_W];

  avgmax_acc #(.DATA_W(DATA_W), .LOG2_N(LOG2_N)) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clr),
    .acc_en (rd_vld),
    .d      (sram.read_data[DATA_W-1:0]),
    .sum    (sum),
    .max    (max_v)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      p_s_q       <= 1'b0;
      base_q      <= '0;
      rd_cnt      <= '0;
      rd_vld      <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      P_out       <= 1'b0;
      p_valid     <= 1'b0;
      avgmax_done <= 1'b0;
    end else begin
      // SRAM data returns one cycle after the issue cycle
      rd_vld      <= issue;
      avgmax_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (avgmax_en) begin
            p_s_q  <= P_s;
            base_q <= base_addr;
            rd_cnt <= '0;
            state  <= S_READ;
          end
        end
        S_READ: begin
          if (sram.ry) begin
            rd_cnt <= rd_cnt + RD_ONE;
            if (rd_cnt == LAST_RD) state <= S_DRAIN;
          end
        end
        S_DRAIN: state <= S_CALC;
        S_CALC: begin
          shreg   <= p_s_q ? avg : max_v;
          bit_cnt <= '0;
          state   <= S_SHIFT;
        end
        S_SHIFT: begin
          p_valid <= 1'b1;
          P_out   <= shreg[DATA_W-1];
          shreg   <= {shreg[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + BIT_ONE;
          if (bit_cnt == LAST_BIT) state <= S_DONE;
        end
        S_DONE: begin
          avgmax_done <= 1'b1;
          p_valid     <= 1'b0;
          P_out       <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_avgmax_serializer.sv
// Scoreboard bench for avgmax_serializer: SRAM model, serial-output monitor and scenario tasks.
module tb_avgmax_serializer;
  import avgmax_serializer_pkg::*;

  localparam int N  = 16;
  localparam int LG = 4;
  localparam int AW = 8;
  localparam int DW = 17;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          avgmax_en = 1'b0;
  logic          P_s = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          P_out, p_valid, busy, avgmax_done;

  avgmax_serializer_if #(.ADDR_W(AW)) sram ();

  avgmax_serializer #(.N_WORDS(N), .LOG2_N(LG), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .avgmax_en   (avgmax_en),
    .P_s         (P_s),
    .base_addr   (base_addr),
    .sram        (sram),
    .P_out       (P_out),
    .p_valid     (p_valid),
    .busy        (busy),
    .avgmax_done (avgmax_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    int            t0;
    int            lat;
  } exp_t;

  logic [31:0]   mem [256];
  exp_t          exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            nbits = 0;
  logic [DW-1:0] shv = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: data valid the cycle after an issued read, junk otherwise
  always @(posedge clk) begin
    if (sram.cs_n === 1'b0) sram.read_data <= mem[sram.address];
    else                    sram.read_data <= $urandom;
  end

  // Output monitor: address order, serial value, bit count and latencies
  always @(negedge clk) begin
    logic [AW-1:0] a;
    exp_t e;
    if (!rst) begin
      nbits = 0;
      shv   = '0;
    end else begin
      if (sram.cs_n === 1'b0) begin
        checks++;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_extra: read issued at %h, none expected", sram.address);
        end else begin
          a = addr_q.pop_front();
          if (sram.address !== a) begin
            errors++;
            $display("FAIL addr_seq: got %h want %h", sram.address, a);
          end
        end
      end
      if (p_valid === 1'b1) begin
        if (nbits == 0 && exp_q.size() != 0) begin
          checks++;
          if ((cyc - exp_q[0].t0) != (exp_q[0].lat - DW)) begin
            errors++;
            $display("FAIL first_bit_lat: got %0d want %0d", cyc - exp_q[0].t0, exp_q[0].lat - DW);
          end
        end
        shv = {shv[DW-2:0], P_out};
        nbits++;
      end
      if (avgmax_done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL done_extra: done pulse with no operation pending");
        end else begin
          e = exp_q.pop_front();
          if (shv !== e.val) begin
            errors++;
            $display("FAIL result: got %h want %h", shv, e.val);
          end
          checks++;
          if (nbits != DW) begin
            errors++;
            $display("FAIL bit_count: got %0d want %0d", nbits, DW);
          end
          checks++;
          if ((cyc - e.t0) != e.lat) begin
            errors++;
            $display("FAIL done_lat: got %0d want %0d", cyc - e.t0, e.lat);
          end
        end
        nbits = 0;
        shv   = '0;
      end
    end
  end

  function automatic logic [DW-1:0] model(input logic ps, input logic [AW-1:0] base);
    logic [DW+LG-1:0] s = '0;
    logic [DW-1:0]    m = '0;
    logic [DW-1:0]    d;
    for (int i = 0; i < N; i++) begin
      d = mem[AW'(int'(base) + i)][DW-1:0];
      s = s + (DW+LG)'(d);
      if (d > m) m = d;
    end
    return ps ? s[DW+LG-1:LG] : m;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance with t0 = acceptance edge.
  task automatic start_op(input logic ps, input logic [AW-1:0] base, input int lat, output int t0);
    exp_t e;
    P_s       = ps;
    base_addr = base;
    avgmax_en = 1'b1;
    for (int i = 0; i < N; i++) addr_q.push_back(AW'(int'(base) + i));
    e.val = model(ps, base);
    @(negedge clk);
    avgmax_en = 1'b0;
    P_s       = ~ps;
    base_addr = AW'($urandom);
    t0    = cyc;
    e.t0  = t0;
    e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (avgmax_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no avgmax_done within %0d cycles", budget);
    end
  endtask

  task automatic fill_ascending(input logic [AW-1:0] base);
    for (int i = 0; i < N; i++) mem[AW'(int'(base) + i)] = 32'(i + 1);
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    sram.ry = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (sram.cs_n !== 1'b1)    begin errors++; $display("FAIL rst_cs_n: got %b want 1", sram.cs_n); end
    checks++; if (sram.we_n !== 1'b1)    begin errors++; $display("FAIL rst_we_n: got %b want 1", sram.we_n); end
    checks++; if (sram.address !== '0)   begin errors++; $display("FAIL rst_addr: got %h want 00", sram.address); end
    checks++; if (P_out !== 1'b0)        begin errors++; $display("FAIL rst_p_out: got %b want 0", P_out); end
    checks++; if (p_valid !== 1'b0)      begin errors++; $display("FAIL rst_p_valid: got %b want 0", p_valid); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (avgmax_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", avgmax_done); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_max();
    int t0;
    fill_ascending(8'h10);
    start_op(1'b0, 8'h10, N + 3 + DW, t0);
    wait_done(100);
    @(negedge clk);
  endtask

  task automatic test_avg();
    int t0;
    start_op(1'b1, 8'h10, N + 3 + DW, t0);
    wait_done(100);
    @(negedge clk);
  endtask

  task automatic test_extremes();
    int t0;
    for (int i = 0; i < N; i++) mem[8'h40 + i] = {15'($urandom | 1), 17'h1FFFF};
    start_op(1'b0, 8'h40, N + 3 + DW, t0);
    wait_done(100);
    start_op(1'b1, 8'h40, N + 3 + DW, t0);
    wait_done(100);
    @(negedge clk);
  endtask

  task automatic test_stall();
    int t0;
    fill_ascending(8'h10);
    start_op(1'b1, 8'h10, N + 3 + DW + 5, t0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 sram.ry = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (sram.cs_n !== 1'b1) begin errors++; $display("FAIL stall_cs_n: cycle %0d got %b want 1", k, sram.cs_n); end
      checks++;
      if (sram.address !== 8'h13) begin errors++; $display("FAIL stall_addr: cycle %0d got %h want 13", k, sram.address); end
      @(posedge clk);
    end
    #1 sram.ry = 1'b1;
    wait_done(100);
    @(negedge clk);
  endtask

  task automatic test_control();
    int t0;
    for (int i = 0; i < N; i++) mem[8'h20 + i] = $urandom;
    start_op(1'b1, 8'h20, N + 3 + DW, t0);
    for (int k = 0; k < 100 && (cyc - t0) < 4; k++) @(negedge clk);
    avgmax_en = 1'b1; P_s = 1'b0; base_addr = 8'h80;
    @(negedge clk);
    avgmax_en = 1'b0;
    for (int k = 0; k < 100 && (cyc - t0) < 25; k++) @(negedge clk);
    avgmax_en = 1'b1; base_addr = 8'h90;
    @(negedge clk);
    avgmax_en = 1'b0;
    // start offered while in DONE must be dropped
    for (int k = 0; k < 100 && (cyc - t0) < 35; k++) @(negedge clk);
    avgmax_en = 1'b1; base_addr = 8'hA0;
    @(negedge clk);
    avgmax_en = 1'b0;
    checks++;
    if (avgmax_done !== 1'b1) begin errors++; $display("FAIL ctl_done: got %b want 1 at cycle %0d", avgmax_done, cyc - t0); end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL ctl_busy: got %b want 0 after ignored start", busy); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    int t0;
    for (int i = 0; i < N; i++) mem[AW'(8'hF8 + i)] = $urandom;
    start_op(1'b0, 8'hF8, N + 3 + DW, t0);
    wait_done(100);
  endtask

  task automatic test_back_to_back();
    int t0;
    start_op(1'b1, 8'hF8, N + 3 + DW, t0);
    wait_done(100);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int t0;
    fill_ascending(8'h10);
    start_op(1'b0, 8'h10, N + 3 + DW, t0);
    for (int k = 0; k < 100 && (cyc - t0) < N + 3 + 6; k++) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (P_out !== 1'b0)       begin errors++; $display("FAIL mid_p_out: got %b want 0", P_out); end
    checks++; if (p_valid !== 1'b0)     begin errors++; $display("FAIL mid_p_valid: got %b want 0", p_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (avgmax_done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", avgmax_done); end
    checks++; if (sram.cs_n !== 1'b1 || sram.address !== '0)
      begin errors++; $display("FAIL mid_sram: cs_n %b addr %h want 1 00", sram.cs_n, sram.address); end
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    rst = 1'b1;
    begin
      bit stray = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (avgmax_done === 1'b1) stray = 1'b1;
      end
      checks++;
      if (stray) begin errors++; $display("FAIL mid_no_done: got done pulse want none"); end
    end
    start_op(1'b1, 8'h10, N + 3 + DW, t0);
    wait_done(100);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    sram.ry = 1'b1;
    test_reset();
    test_max();
    test_avg();
    test_extremes();
    test_stall();
    test_control();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL leftovers: results %0d reads %0d still pending", exp_q.size(), addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
